// File: rtl/vx_pending_tags.sv
// vx_pending_tags: tag allocator plus per-tag metadata table for outstanding
// requests, with built-in occupancy tracking (empty/full/size).
// Optional build macro: VX_PENDING_TAGS_BYPASS_EN. When defined, a release
// can hand its tag straight to an acquirer in the same cycle.
module vx_pending_tags #(
    parameter int SIZE  = 4,
    parameter int DATAW = 1,
    parameter int TAGW  = $clog2(SIZE),
    parameter int SIZEW = $clog2(SIZE + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_acquire_valid,
    input  logic [DATAW-1:0] i_acquire_data,
    output logic             o_acquire_ready,
    output logic [TAGW-1:0]  o_acquire_tag,
    input  logic             i_release_valid,
    input  logic [TAGW-1:0]  i_release_tag,
    output logic [DATAW-1:0] o_release_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [SIZEW-1:0] o_size
);

    logic [SIZE-1:0]  r_valid;
    logic [DATAW-1:0] r_data [SIZE];
    logic             r_empty;
    logic             r_full;
    logic [SIZEW-1:0] r_used;

    logic             w_release_in_range;
    logic [SIZE-1:0]  w_release_onehot;
    logic             w_release_hit;
    logic             w_release_illegal;
    logic [SIZE-1:0]  w_free_mask;
    logic [TAGW-1:0]  w_acquire_tag;
    logic [SIZE-1:0]  w_acquire_onehot;
    logic             w_acquire_fire;
    logic             w_acquire_only;
    logic             w_release_only;
    logic [SIZE-1:0]  w_valid_next;

    // A release only counts when it names a tag that is actually outstanding;
    // anything else is ignored so the valid mask and count stay consistent.
    assign w_release_in_range = int'(i_release_tag) < SIZE;
    assign w_release_onehot   = w_release_in_range ? (SIZE'(1) << i_release_tag) : '0;
    assign w_release_hit      = i_release_valid && (|(r_valid & w_release_onehot));
    assign w_release_illegal  = i_release_valid && !w_release_hit;

`ifdef VX_PENDING_TAGS_BYPASS_EN
    // The returning tag is offered to the acquirer in the same cycle; only a
    // genuine release may open up a full table.
    assign w_free_mask     = ~r_valid | (i_release_valid ? w_release_onehot : '0);
    assign o_acquire_ready = !r_full || w_release_hit;
`else
    assign w_free_mask     = ~r_valid;
    assign o_acquire_ready = !r_full;
`endif

    // Priority encoder: grant the lowest-numbered free tag.
    always_comb begin
        w_acquire_tag = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (w_free_mask[i]) begin
                w_acquire_tag = TAGW'(i);
            end
        end
    end

    assign o_acquire_tag    = w_acquire_tag;
    assign w_acquire_onehot = SIZE'(1) << w_acquire_tag;
    assign w_acquire_fire   = i_acquire_valid && o_acquire_ready;
    assign w_acquire_only   = w_acquire_fire && !w_release_hit;
    assign w_release_only   = w_release_hit && !w_acquire_fire;

    // Next valid mask: clear the released tag first so a bypassed re-grant of
    // the same tag leaves it set.
    always_comb begin
        w_valid_next = r_valid;
        if (w_release_hit) begin
            w_valid_next = w_valid_next & ~w_release_onehot;
        end
        if (w_acquire_fire) begin
            w_valid_next = w_valid_next | w_acquire_onehot;
        end
    end

    // Valid mask register; reset drops every outstanding tag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_next;
        end
    end

    // Metadata storage; contents are meaningless until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_acquire_fire) begin
            r_data[w_acquire_tag] <= i_acquire_data;
        end
    end

    // Occupancy counter with registered empty/full flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_used  <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else if (w_acquire_only) begin
            r_used  <= r_used + SIZEW'(1);
            r_empty <= 1'b0;
            if (r_used == SIZEW'(SIZE - 1)) begin
                r_full <= 1'b1;
            end
        end else if (w_release_only) begin
            r_used <= r_used - SIZEW'(1);
            r_full <= 1'b0;
            if (r_used == SIZEW'(1)) begin
                r_empty <= 1'b1;
            end
        end
    end

    // Flag a release of a tag that is not outstanding.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            assert (!w_release_illegal)
                else $warning("vx_pending_tags: release of unallocated tag %0d", i_release_tag);
        end
    end

    assign o_release_data = w_release_in_range ? r_data[i_release_tag] : '0;
    assign o_empty        = r_empty;
    assign o_full         = r_full;
    assign o_size         = r_full ? SIZEW'(SIZE) : r_used;

endmodule
